// File: rtl/elevator_pkg.sv
// elevator_pkg: shared level/queue constants, car state encoding and tail saturation
package elevator_pkg;
  localparam int LVL_W   = 2;
  localparam int NUM_LVL = 4;
  localparam int QDEPTH  = 6;
  localparam int TAIL_W  = 3;
  localparam int QUEUE_W = 12;
  typedef enum logic [1:0] {IDLE, MOVE, CHECK, DOOR} car_state_t;
  function automatic logic [TAIL_W-1:0] sat_tail(input logic [TAIL_W-1:0] t);
    return t > TAIL_W'(QDEPTH) ? TAIL_W'(QDEPTH) : t;
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter; expire marks the last counted cycle (value==1)
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);
  always_ff @(posedge clk)
    if (rst) value <= '0;
    else if (load) value <= load_val;
    else if (value != '0) value <= value - W'(1);
  assign expire = value == W'(1);
endmodule

// File: rtl/car_controller.sv
// car_controller: elevator car FSM consuming the request queue; CAR_DOOR_HOLD_EN adds a door_hold input
module car_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 30,
  parameter int DOOR_CYCLES   = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [QUEUE_W-1:0] queue,
  input  logic [TAIL_W-1:0]  tail,
  input  logic               stop_at_pos_lvl,
`ifdef CAR_DOOR_HOLD_EN
  input  logic               door_hold,
`endif
  output logic [LVL_W-1:0]   pos_lvl,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic               pop
);
  localparam int TMAX = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  car_state_t state, next_state;
  logic [LVL_W-1:0] head, next_pos;
  logic [TW-1:0] travel_val, door_val;
  logic empty, hit, hold, decide, next_dir, next_pop;
  logic travel_load, door_load, travel_exp, door_exp;
  logic unused_ok;
  assign head = queue[LVL_W-1:0];
  assign empty = sat_tail(tail) == '0;
  assign hit = !empty && head == pos_lvl;
  assign decide = state == IDLE || state == CHECK;
  assign unused_ok = ^{travel_val, door_val};
`ifdef CAR_DOOR_HOLD_EN
  assign hold = door_hold && state == DOOR;
`else
  assign hold = 1'b0;
`endif
  cycle_timer #(.W(TW)) u_travel (
    .clk(clk), .rst(rst), .load(travel_load), .load_val(TW'(TRAVEL_CYCLES)),
    .value(travel_val), .expire(travel_exp)
  );
  cycle_timer #(.W(TW)) u_door (
    .clk(clk), .rst(rst), .load(door_load), .load_val(TW'(DOOR_CYCLES)),
    .value(door_val), .expire(door_exp)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      pos_lvl   <= '0;
      dir_up    <= 1'b0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      pop       <= 1'b0;
    end else begin
      state     <= next_state;
      pos_lvl   <= next_pos;
      dir_up    <= next_dir;
      moving    <= next_state == MOVE || next_state == CHECK;
      door_open <= next_state == DOOR;
      pop       <= next_pop;
    end
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = empty ? IDLE : hit ? DOOR : MOVE;
      MOVE:    next_state = travel_exp ? CHECK : MOVE;
      CHECK:   next_state = (hit || stop_at_pos_lvl) ? DOOR : empty ? IDLE : MOVE;
      DOOR:    next_state = (door_exp && !hold) ? IDLE : DOOR;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    next_pos = (state == MOVE && travel_exp)
      ? (dir_up ? (pos_lvl == LVL_W'(NUM_LVL - 1) ? pos_lvl : pos_lvl + LVL_W'(1))
                : (pos_lvl == '0 ? pos_lvl : pos_lvl - LVL_W'(1)))
      : pos_lvl;
    travel_load = decide && next_state == MOVE;
    next_dir = travel_load ? head > pos_lvl : dir_up;
    door_load = next_state == DOOR && (state != DOOR || hold);
    next_pop = decide && hit;
  end
endmodule

// File: tb/tb_car_controller.sv
// tb_car_controller: directed checks of car_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=3
module tb_car_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] queue = '0;
  logic [2:0] tail = '0;
  logic stop_at_pos_lvl = 1'b0;
  logic door_hold = 1'b0;
  logic [1:0] pos_lvl;
  logic dir_up, moving, door_open, pop;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  car_controller #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .queue(queue), .tail(tail), .stop_at_pos_lvl(stop_at_pos_lvl),
`ifdef CAR_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .pos_lvl(pos_lvl), .dir_up(dir_up), .moving(moving), .door_open(door_open), .pop(pop)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input int p, input int m, input int d, input int pp);
    check({tag, "_pos"}, int'(pos_lvl), p);
    check({tag, "_moving"}, int'(moving), m);
    check({tag, "_door"}, int'(door_open), d);
    check({tag, "_pop"}, int'(pop), pp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic request(input logic [1:0] h);
    queue = {10'd0, h};
    tail = 3'd1;
  endtask
  int door_cnt;
  initial begin
    tail = 3'd3;
    queue = 12'h002;
    tick(1);
    outs("rst1", 0, 0, 0, 0);
    tick(1);
    outs("rst2", 0, 0, 0, 0);
    tail = 3'd0;
    rst = 1'b0;
    tick(1);
    outs("idle_empty", 0, 0, 0, 0);
    request(2'd2);
    tick(1);
    outs("up_start", 0, 1, 0, 0);
    check("up_dir", int'(dir_up), 1);
    tick(4);
    outs("up_l1", 1, 1, 0, 0);
    tick(5);
    outs("up_l2", 2, 1, 0, 0);
    tick(1);
    outs("up_door", 2, 0, 1, 1);
    tail = 3'd0;
    tick(1);
    outs("up_door2", 2, 0, 1, 0);
    tick(1);
    outs("up_door3", 2, 0, 1, 0);
    tick(1);
    outs("up_closed", 2, 0, 0, 0);
    request(2'd1);
    tick(1);
    outs("dn_start", 2, 1, 0, 0);
    check("dn_dir", int'(dir_up), 0);
    tick(4);
    outs("dn_l1", 1, 1, 0, 0);
    tick(1);
    outs("dn_door", 1, 0, 1, 1);
    tail = 3'd0;
    tick(3);
    outs("dn_closed", 1, 0, 0, 0);
    request(2'd1);
    tick(1);
    outs("here_door", 1, 0, 1, 1);
    tail = 3'd0;
    tick(1);
    outs("here_door2", 1, 0, 1, 0);
    tick(1);
    outs("here_door3", 1, 0, 1, 0);
    tick(1);
    outs("here_closed", 1, 0, 0, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    outs("rst_idle", 0, 0, 0, 0);
    queue = 12'h00B;
    tail = 3'd2;
    tick(1);
    check("stop_dir", int'(dir_up), 1);
    tick(4);
    outs("stop_l1", 1, 1, 0, 0);
    tick(5);
    outs("stop_l2", 2, 1, 0, 0);
    stop_at_pos_lvl = 1'b1;
    tick(1);
    outs("stop_door", 2, 0, 1, 0);
    stop_at_pos_lvl = 1'b0;
    tail = 3'd1;
    tick(3);
    outs("stop_closed", 2, 0, 0, 0);
    tick(1);
    outs("resume", 2, 1, 0, 0);
    check("resume_dir", int'(dir_up), 1);
    tick(4);
    outs("resume_l3", 3, 1, 0, 0);
    tick(1);
    outs("l3_door", 3, 0, 1, 1);
    tail = 3'd0;
    tick(1);
    outs("l3_door2", 3, 0, 1, 0);
    tick(2);
    outs("l3_closed", 3, 0, 0, 0);
    request(2'd0);
    tick(1);
    outs("mv_start", 3, 1, 0, 0);
    check("mv_dir", int'(dir_up), 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    outs("mv_rst", 0, 0, 0, 0);
    check("mv_rst_dir", int'(dir_up), 0);
    rst = 1'b0;
    tail = 3'd0;
    tick(1);
    outs("mv_rst_after", 0, 0, 0, 0);
    request(2'd3);
    tick(2);
    tail = 3'd0;
    tick(3);
    outs("halt_l1", 1, 1, 0, 0);
    tick(1);
    outs("halt", 1, 0, 0, 0);
    tick(2);
    outs("halt_stay", 1, 0, 0, 0);
    request(2'd1);
    tick(1);
    outs("dr_door", 1, 0, 1, 1);
    tail = 3'd0;
    rst = 1'b1;
    tick(1);
    outs("dr_rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick(1);
    outs("dr_rst_after", 0, 0, 0, 0);
`ifdef CAR_DOOR_HOLD_EN
    request(2'd0);
    door_hold = 1'b1;
    door_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (door_open) door_cnt++;
      if (i == 0) tail = 3'd0;
      if (i == 5) door_hold = 1'b0;
    end
    check("hold_len", door_cnt, 8);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
